board_ctrl: RTL

- Parametrised N×N tic-tac-toe game controller. It owns the board cell registers, turn order, move legality, sequential win/draw detection and score counters.
- Drives the board, state and score inputs of pixel_Gen directly, replacing the fixed 3×3 constant registers held in top.
- Moves arrive from the input/mouse logic over a valid/ready handshake.

---
 rtl/board_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/board_ctrl.sv
// N x N tic-tac-toe controller: board registers, turn order, move legality, sequential line scan, scores.
// Optional forced turn pass on idle PLAY when MOVE_TIMEOUT_EN is defined.
module board_ctrl #(
    parameter int BOARD_N        = 3,
    parameter int SCORE_W        = 9,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    localparam int IW            = $clog2(BOARD_N)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_game,
    input  logic                           move_valid,
    output logic                           move_ready,
    input  logic [IW-1:0]                  move_row,
    input  logic [IW-1:0]                  move_col,
    output logic                           move_err,
    output logic [2*BOARD_N*BOARD_N-1:0]   cells,
    output logic                           turn,
    output logic [2:0]                     state,
    output logic [SCORE_W-1:0]             x_score,
    output logic [SCORE_W-1:0]             o_score
`ifdef MOVE_TIMEOUT_EN
    ,
    output logic                           timeout_pulse
`endif
);

    localparam int NC = BOARD_N * BOARD_N;
    localparam int NL = 2 * BOARD_N + 2;
    localparam int LW = $clog2(NL + 1);
    localparam int FW = $clog2(NC + 1);

    localparam logic [2:0] S_MENU  = 3'd0;
    localparam logic [2:0] S_PLAY  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_XWIN  = 3'd3;
    localparam logic [2:0] S_OWIN  = 3'd4;
    localparam logic [2:0] S_DRAW  = 3'd5;

    localparam logic [2*NC-1:0] EMPTY   = {NC{2'b10}};
    localparam logic [IW:0]     N_L     = (IW + 1)'(BOARD_N);
    localparam logic [LW-1:0]   IDX_END = LW'(NL);
    localparam logic [FW-1:0]   FULL    = FW'(NC);

    if (BOARD_N < 3 || BOARD_N > 8 || SCORE_W < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("board_ctrl: parameter out of range");
    end

    logic [2*NC-1:0]    cells_q, cells_d;
    logic               turn_q, turn_d;
    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] xs_q, xs_d, os_q, os_d;
    logic               err_q, err_d;
    logic [FW-1:0]      filled_q, filled_d;
    logic [LW-1:0]      idx_q, idx_d;
    logic               win_q, win_d;

    logic in_range, tgt_empty, legal, accept, line_hit;
    int   tgt_idx;

    assign move_ready = (state_q == S_PLAY) && !new_game;
    assign accept     = move_valid && move_ready;

    // Out-of-range coordinates never index the board.
    always_comb begin
        in_range  = ({1'b0, move_row} < N_L) && ({1'b0, move_col} < N_L);
        tgt_idx   = int'(move_row) * BOARD_N + int'(move_col);
        tgt_empty = 1'b0;
        if (in_range)
            tgt_empty = (cells_q[2*tgt_idx +: 2] == 2'b10);
        legal = in_range && tgt_empty;
    end

    // Cell walk for the line selected by idx_q; the decide cycle maps onto the anti-diagonal harmlessly.
    always_comb begin
        int r, c;
        r        = 0;
        c        = 0;
        line_hit = 1'b1;
        for (int k = 0; k < BOARD_N; k++) begin
            if (int'(idx_q) < BOARD_N) begin
                r = int'(idx_q);
                c = k;
            end else if (int'(idx_q) < 2 * BOARD_N) begin
                r = k;
                c = int'(idx_q) - BOARD_N;
            end else if (int'(idx_q) == 2 * BOARD_N) begin
                r = k;
                c = k;
            end else begin
                r = k;
                c = BOARD_N - 1 - k;
            end
            if (cells_q[2*(r*BOARD_N + c) +: 2] != {1'b0, turn_q})
                line_hit = 1'b0;
        end
    end

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_pulse_q, to_fire;

    assign to_fire = (state_q == S_PLAY) && !new_game && !accept && (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (new_game || state_q != S_PLAY || accept || to_fire)
            to_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q   <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            to_pulse_q <= to_fire;
        end
    end

    assign timeout_pulse = to_pulse_q;
`endif

    always_comb begin
        cells_d  = cells_q;
        turn_d   = turn_q;
        state_d  = state_q;
        xs_d     = xs_q;
        os_d     = os_q;
        err_d    = 1'b0;
        filled_d = filled_q;
        idx_d    = idx_q;
        win_d    = win_q;

        if (new_game) begin
            cells_d  = EMPTY;
            turn_d   = 1'b0;
            filled_d = '0;
            idx_d    = '0;
            win_d    = 1'b0;
            state_d  = S_PLAY;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (accept) begin
                        if (legal) begin
                            cells_d[2*tgt_idx +: 2] = {1'b0, turn_q};
                            filled_d = filled_q + FW'(1);
                            idx_d    = '0;
                            win_d    = 1'b0;
                            state_d  = S_CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`ifdef MOVE_TIMEOUT_EN
                    else if (to_fire) begin
                        turn_d = ~turn_q;
                    end
`endif
                end
                S_CHECK: begin
                    if (idx_q == IDX_END) begin
                        // Win outranks draw, so a line completed by the last cell still scores.
                        if (win_q) begin
                            if (turn_q) begin
                                state_d = S_OWIN;
                                if (os_q != {SCORE_W{1'b1}}) os_d = os_q + SCORE_W'(1);
                            end else begin
                                state_d = S_XWIN;
                                if (xs_q != {SCORE_W{1'b1}}) xs_d = xs_q + SCORE_W'(1);
                            end
                        end else if (filled_q == FULL) begin
                            state_d = S_DRAW;
                        end else begin
                            turn_d  = ~turn_q;
                            state_d = S_PLAY;
                        end
                    end else begin
                        win_d = win_q | line_hit;
                        idx_d = idx_q + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cells_q  <= EMPTY;
            turn_q   <= 1'b0;
            state_q  <= S_MENU;
            xs_q     <= '0;
            os_q     <= '0;
            err_q    <= 1'b0;
            filled_q <= '0;
            idx_q    <= '0;
            win_q    <= 1'b0;
        end else begin
            cells_q  <= cells_d;
            turn_q   <= turn_d;
            state_q  <= state_d;
            xs_q     <= xs_d;
            os_q     <= os_d;
            err_q    <= err_d;
            filled_q <= filled_d;
            idx_q    <= idx_d;
            win_q    <= win_d;
        end
    end

    assign cells    = cells_q;
    assign turn     = turn_q;
    assign state    = state_q;
    assign x_score  = xs_q;
    assign o_score  = os_q;
    assign move_err = err_q;

endmodule
